// File: rtl/stage_sequencer.sv
// stage_sequencer -- parametrised multi-cycle instruction stage controller.
//
// Steps each instruction through NUM_STAGES stages. The fetch stage (always)
// and the memory stage (when the instruction accesses data memory) issue a bus
// request. Such a stage completes only once MEM_MFC is seen. A run/halt/
// single-step front end and a sticky fault state sit around the stage counter.
//
// Optional feature: define STAGE_SEQ_TIMEOUT_EN to add the memory watchdog.
// After TIMEOUT consecutive wait cycles without MEM_MFC, the sequencer faults
// with code 10. Without the macro, a wait lasts until MEM_MFC or MEM_ERROR.
//
// Ports:
//   Clock         in   rising-edge system clock
//   Reset         in   asynchronous active-high reset, clears all state
//   Run           in   level, free-run instructions
//   Step          in   pulse, starts one instruction while halted
//   Mem_Access    in   instruction accesses data memory (sampled in MEM_STAGE)
//   Mem_Write     in   1 = store, 0 = load (sampled with Mem_Access)
//   MEM_MFC       in   memory function complete
//   MEM_ERROR     in   address not assigned
//   Stage         out  current stage 1..NUM_STAGES, 0 when halted/faulted
//   Stage_Strobe  out  one-hot, bit k-1 high in the cycle stage k completes
//   MEM_r_w_z_z   out  bus command: 00 read, 01 write, 10 high impedance
//   Mem_Wait      out  request outstanding, MFC not yet seen
//   Fault         out  sticky fault flag
//   Fault_Code    out  01 MEM_ERROR, 10 timeout, 00 none
//   Instr_Count   out  retired instruction count (wraps)

module stage_sequencer #(
  parameter int NUM_STAGES  = 5,
  parameter int STAGE_W     = 3,
  parameter int FETCH_STAGE = 1,
  parameter int MEM_STAGE   = 4,
  parameter int TIMEOUT     = 15,
  parameter int COUNT_W     = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic                  Step,
  input  logic                  Mem_Access,
  input  logic                  Mem_Write,
  input  logic                  MEM_MFC,
  input  logic                  MEM_ERROR,
  output logic [STAGE_W-1:0]    Stage,
  output logic [NUM_STAGES-1:0] Stage_Strobe,
  output logic [1:0]            MEM_r_w_z_z,
  output logic                  Mem_Wait,
  output logic                  Fault,
  output logic [1:0]            Fault_Code,
  output logic [COUNT_W-1:0]    Instr_Count
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [STAGE_W-1:0]   stage_r, stage_s;
  logic                 step_req_r, step_req_s;
  logic                 req_write_r, req_write_s;
  logic                 mem_wait_r, mem_wait_s;
  logic                 fault_r, fault_s;
  logic [1:0]           fault_code_r, fault_code_s;
  logic [COUNT_W-1:0]   count_r, count_s;
  logic                 is_fetch_s, is_mem_s, req_s, err_s, done_s, last_s;
`ifdef STAGE_SEQ_TIMEOUT_EN
  logic [7:0]           wd_r, wd_s;
`endif

  // Reject parameter sets the stage counter or watchdog cannot represent.
  if (NUM_STAGES < 2 || NUM_STAGES > 7 || (1 << STAGE_W) <= NUM_STAGES ||
      FETCH_STAGE < 1 || FETCH_STAGE > NUM_STAGES ||
      MEM_STAGE < 1 || MEM_STAGE > NUM_STAGES ||
      TIMEOUT < 1 || TIMEOUT > 255 || COUNT_W < 1) begin : g_bad_params
    $error("stage_sequencer: illegal parameter set");
  end

  // A cycle is a bus request when running in fetch, or in the memory stage of
  // an accessing instruction, and throughout every wait cycle.
  assign is_fetch_s = (stage_r == STAGE_W'(FETCH_STAGE));
  assign is_mem_s   = (stage_r == STAGE_W'(MEM_STAGE)) && Mem_Access;
  assign req_s      = ((state_r == S_RUN) && (is_fetch_s || is_mem_s)) ||
                      (state_r == S_WAIT);
  // MEM_ERROR outranks MEM_MFC, so an erroring request never completes.
  assign err_s      = req_s && MEM_ERROR;
  assign done_s     = ((state_r == S_RUN) && !req_s) ||
                      (req_s && MEM_MFC && !MEM_ERROR);
  assign last_s     = done_s && (stage_r == STAGE_W'(NUM_STAGES));

  assign Stage       = stage_r;
  assign Mem_Wait    = mem_wait_r;
  assign Fault       = fault_r;
  assign Fault_Code  = fault_code_r;
  assign Instr_Count = count_r;

  // State register and registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r      <= S_HALT;
      stage_r      <= {STAGE_W{1'b0}};
      step_req_r   <= 1'b0;
      req_write_r  <= 1'b0;
      mem_wait_r   <= 1'b0;
      fault_r      <= 1'b0;
      fault_code_r <= 2'b00;
      count_r      <= {COUNT_W{1'b0}};
`ifdef STAGE_SEQ_TIMEOUT_EN
      wd_r         <= 8'd0;
`endif
    end else begin
      state_r      <= state_s;
      stage_r      <= stage_s;
      step_req_r   <= step_req_s;
      req_write_r  <= req_write_s;
      mem_wait_r   <= mem_wait_s;
      fault_r      <= fault_s;
      fault_code_r <= fault_code_s;
      count_r      <= count_s;
`ifdef STAGE_SEQ_TIMEOUT_EN
      wd_r         <= wd_s;
`endif
    end
  end

  // Next-state logic: stage advance, wait entry/exit, faults, retirement.
  always_comb begin
    state_s      = state_r;
    stage_s      = stage_r;
    step_req_s   = step_req_r;
    req_write_s  = req_write_r;
    mem_wait_s   = mem_wait_r;
    fault_s      = fault_r;
    fault_code_s = fault_code_r;
    count_s      = count_r;
`ifdef STAGE_SEQ_TIMEOUT_EN
    wd_s         = wd_r;
`endif
    case (state_r)
      S_HALT: begin
        if (Run || Step) begin
          state_s    = S_RUN;
          stage_s    = STAGE_W'(1'b1);
          // A Step start runs one instruction even if Run rises meanwhile.
          step_req_s = Step;
        end else begin
          state_s    = S_HALT;
        end
      end
      S_RUN, S_WAIT: begin
        if (err_s) begin
          state_s      = S_FAULT;
          stage_s      = {STAGE_W{1'b0}};
          step_req_s   = 1'b0;
          mem_wait_s   = 1'b0;
          fault_s      = 1'b1;
          fault_code_s = 2'b01;
        end else if (done_s) begin
          mem_wait_s = 1'b0;
          if (last_s) begin
            count_s = count_r + COUNT_W'(1'b1);
            if (Run && !step_req_r) begin
              state_s = S_RUN;
              stage_s = STAGE_W'(1'b1);
            end else begin
              state_s    = S_HALT;
              stage_s    = {STAGE_W{1'b0}};
              step_req_s = 1'b0;
            end
          end else begin
            state_s = S_RUN;
            stage_s = stage_r + STAGE_W'(1'b1);
          end
        end else if (state_r == S_RUN) begin
          // First request cycle without MFC: freeze the command and wait.
          state_s     = S_WAIT;
          mem_wait_s  = 1'b1;
          req_write_s = is_fetch_s ? 1'b0 : Mem_Write;
`ifdef STAGE_SEQ_TIMEOUT_EN
          wd_s        = 8'd0;
`endif
        end else begin
`ifdef STAGE_SEQ_TIMEOUT_EN
          // wd_r counts the wait cycles already spent without MFC.
          if (wd_r == 8'(TIMEOUT - 1)) begin
            state_s      = S_FAULT;
            stage_s      = {STAGE_W{1'b0}};
            step_req_s   = 1'b0;
            mem_wait_s   = 1'b0;
            fault_s      = 1'b1;
            fault_code_s = 2'b10;
          end else begin
            wd_s = wd_r + 8'd1;
          end
`else
          state_s = S_WAIT;
`endif
        end
      end
      S_FAULT: begin
        state_s = S_FAULT;
      end
      default: begin
        state_s = S_FAULT;
      end
    endcase
  end

  // Combinational outputs: completion strobe and bus command.
  always_comb begin
    Stage_Strobe = {NUM_STAGES{1'b0}};
    MEM_r_w_z_z  = 2'b10;
    if (done_s) begin
      Stage_Strobe = NUM_STAGES'(1'b1) << (stage_r - STAGE_W'(1'b1));
    end else begin
      Stage_Strobe = {NUM_STAGES{1'b0}};
    end
    case (state_r)
      S_RUN: begin
        if (is_fetch_s) begin
          MEM_r_w_z_z = 2'b00;
        end else if (is_mem_s) begin
          MEM_r_w_z_z = {1'b0, Mem_Write};
        end else begin
          MEM_r_w_z_z = 2'b10;
        end
      end
      S_WAIT:  MEM_r_w_z_z = {1'b0, req_write_r};
      default: MEM_r_w_z_z = 2'b10;
    endcase
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer (default parameters).
// Stimulus pushes expected completion records (strobe, bus, stage) into a
// queue. A negedge monitor pops and compares one record on every nonzero
// Stage_Strobe. The stimulus thread adds direct checks of registered state.
module tb_stage_sequencer;

  logic        Clock = 1'b0;
  logic        Reset, Run, Step, Mem_Access, Mem_Write, MEM_MFC, MEM_ERROR;
  logic [2:0]  Stage;
  logic [4:0]  Stage_Strobe;
  logic [1:0]  MEM_r_w_z_z;
  logic        Mem_Wait, Fault;
  logic [1:0]  Fault_Code;
  logic [31:0] Instr_Count;

  int checks = 0;
  int errors = 0;
  int waitcnt;

  typedef struct packed {
    logic [4:0] strobe;
    logic [1:0] bus;
    logic [2:0] stage;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  stage_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Step(Step),
    .Mem_Access(Mem_Access), .Mem_Write(Mem_Write),
    .MEM_MFC(MEM_MFC), .MEM_ERROR(MEM_ERROR),
    .Stage(Stage), .Stage_Strobe(Stage_Strobe), .MEM_r_w_z_z(MEM_r_w_z_z),
    .Mem_Wait(Mem_Wait), .Fault(Fault), .Fault_Code(Fault_Code),
    .Instr_Count(Instr_Count)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Expected completions for stages first..last; stage 1 reads, stage 4 uses mem_bus.
  task automatic push_instr(input int first, input int last, input logic [1:0] mem_bus);
    exp_t e;
    logic [4:0] one;
    one = 5'b00001;
    for (int k = first; k <= last; k++) begin
      e.strobe = one << (k - 1);
      e.bus    = (k == 1) ? 2'b00 : ((k == 4) ? mem_bus : 2'b10);
      e.stage  = 3'(k);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every completion strobe must match the next expected record.
  always @(negedge Clock) begin
    if (Stage_Strobe != 5'b00000) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe_unexpected got=%b want=none", Stage_Strobe);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe", 32'(Stage_Strobe), 32'(mon_e.strobe));
        chk("strobe_bus", 32'(MEM_r_w_z_z), 32'(mon_e.bus));
        chk("strobe_stage", 32'(Stage), 32'(mon_e.stage));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    Reset = 1'b1; Run = 1'b0; Step = 1'b0; Mem_Access = 1'b0; Mem_Write = 1'b0;
    MEM_MFC = 1'b0; MEM_ERROR = 1'b0;
    tick(); tick();
    chk("rst_stage", 32'(Stage), 32'd0);
    chk("rst_strobe", 32'(Stage_Strobe), 32'd0);
    chk("rst_bus", 32'(MEM_r_w_z_z), 32'h2);
    chk("rst_wait", 32'(Mem_Wait), 32'd0);
    chk("rst_fault", 32'(Fault), 32'd0);
    chk("rst_code", 32'(Fault_Code), 32'd0);
    chk("rst_count", Instr_Count, 32'd0);
    Reset = 1'b0;

    // Free run, no memory access; Run dropped in stage 2 of instruction 2.
    MEM_MFC = 1'b1; Run = 1'b1;
    push_instr(1, 5, 2'b10);
    push_instr(1, 5, 2'b10);
    tick();
    chk("t1_stage1", 32'(Stage), 32'd1);
    chk("t1_fetch_bus", 32'(MEM_r_w_z_z), 32'h0);
    repeat (4) tick();
    chk("t1_count_before", Instr_Count, 32'd0);
    tick();
    chk("t1_count1", Instr_Count, 32'd1);
    chk("t1_restart", 32'(Stage), 32'd1);
    tick();
    Run = 1'b0;
    repeat (4) tick();
    chk("t1_count2", Instr_Count, 32'd2);
    chk("t1_halt", 32'(Stage), 32'd0);
    tick();
    chk("t1_stay_halt", 32'(Stage), 32'd0);

    // Single step; Run rising mid-instruction must not extend the step.
    push_instr(1, 5, 2'b10);
    Step = 1'b1;
    tick();
    Step = 1'b0;
    chk("t5_stage1", 32'(Stage), 32'd1);
    tick(); tick();
    Run = 1'b1;
    tick(); tick(); tick();
    chk("t5_halt", 32'(Stage), 32'd0);
    chk("t5_count", Instr_Count, 32'd3);
    Run = 1'b0;
    tick();
    chk("t5_stay_halt", 32'(Stage), 32'd0);

    // Store whose MFC arrives in the 4th cycle of stage 4.
    Mem_Access = 1'b1; Mem_Write = 1'b1; MEM_MFC = 1'b1; Run = 1'b1;
    push_instr(1, 5, 2'b01);
    tick(); tick(); tick();
    MEM_MFC = 1'b0; Run = 1'b0;
    tick();
    waitcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) MEM_MFC = 1'b1;
      chk("t2_bus", 32'(MEM_r_w_z_z), 32'h1);
      chk("t2_stage", 32'(Stage), 32'd4);
      if (Mem_Wait) waitcnt++;
      tick();
    end
    chk("t2_wait_cycles", 32'(waitcnt), 32'd3);
    chk("t2_wait_clear", 32'(Mem_Wait), 32'd0);
    chk("t2_stage5", 32'(Stage), 32'd5);
    tick();
    chk("t2_count", Instr_Count, 32'd4);

    // Load with MEM_ERROR and MFC together in stage 4.
    Mem_Write = 1'b0; Run = 1'b1;
    push_instr(1, 3, 2'b00);
    tick(); tick(); tick();
    MEM_ERROR = 1'b1;
    tick();
    chk("t4_bus_load", 32'(MEM_r_w_z_z), 32'h0);
    chk("t4_no_strobe", 32'(Stage_Strobe), 32'd0);
    tick();
    chk("t4_fault", 32'(Fault), 32'd1);
    chk("t4_code", 32'(Fault_Code), 32'h1);
    chk("t4_stage", 32'(Stage), 32'd0);
    chk("t4_bus", 32'(MEM_r_w_z_z), 32'h2);
    chk("t4_wait", 32'(Mem_Wait), 32'd0);
    chk("t4_count", Instr_Count, 32'd4);
    MEM_ERROR = 1'b0; Step = 1'b1;
    tick(); tick();
    Step = 1'b0;
    chk("t4_sticky", 32'(Fault), 32'd1);
    chk("t4_sticky_stage", 32'(Stage), 32'd0);
    chk("t4_frozen_count", Instr_Count, 32'd4);
    #2 Reset = 1'b1;
    #1;
    chk("t4_rst_fault", 32'(Fault), 32'd0);
    chk("t4_rst_count", Instr_Count, 32'd0);
    Run = 1'b0; Mem_Access = 1'b0;
    tick();
    Reset = 1'b0;

    // No MFC during fetch: watchdog fault (or indefinite wait without it).
    MEM_MFC = 1'b0; Run = 1'b1;
    tick();
    chk("t3_stage1", 32'(Stage), 32'd1);
    chk("t3_bus", 32'(MEM_r_w_z_z), 32'h0);
    chk("t3_wait0", 32'(Mem_Wait), 32'd0);
    repeat (15) tick();
    chk("t3_waiting", 32'(Mem_Wait), 32'd1);
    chk("t3_no_fault_yet", 32'(Fault), 32'd0);
    chk("t3_wait_bus", 32'(MEM_r_w_z_z), 32'h0);
    tick();
`ifdef STAGE_SEQ_TIMEOUT_EN
    chk("t3_fault", 32'(Fault), 32'd1);
    chk("t3_code", 32'(Fault_Code), 32'h2);
    chk("t3_stage", 32'(Stage), 32'd0);
    chk("t3_bus_z", 32'(MEM_r_w_z_z), 32'h2);
    chk("t3_wait_clr", 32'(Mem_Wait), 32'd0);
`else
    chk("t3_still_wait", 32'(Mem_Wait), 32'd1);
    chk("t3_no_timeout", 32'(Fault), 32'd0);
    MEM_ERROR = 1'b1;
    tick();
    MEM_ERROR = 1'b0;
    chk("t3_err_fault", 32'(Fault), 32'd1);
    chk("t3_err_code", 32'(Fault_Code), 32'h1);
`endif
    Step = 1'b1;
    tick();
    Step = 1'b0;
    tick();
    chk("t3_sticky", 32'(Fault), 32'd1);
    chk("t3_sticky_stage", 32'(Stage), 32'd0);
    #2 Reset = 1'b1;
    #1;
    chk("t3_rst_fault", 32'(Fault), 32'd0);
    chk("t3_rst_code", 32'(Fault_Code), 32'd0);
    Run = 1'b0;
    tick();
    Reset = 1'b0;

    // Reset in the middle of a stage-4 store wait.
    MEM_MFC = 1'b1; Mem_Access = 1'b1; Mem_Write = 1'b1; Run = 1'b1;
    push_instr(1, 5, 2'b01);
    push_instr(1, 3, 2'b01);
    repeat (5) tick();
    tick();
    chk("t6_count1", Instr_Count, 32'd1);
    tick(); tick();
    MEM_MFC = 1'b0;
    tick(); tick();
    chk("t6_waiting", 32'(Mem_Wait), 32'd1);
    chk("t6_stage4", 32'(Stage), 32'd4);
    #2 Reset = 1'b1;
    #1;
    chk("t6_stage", 32'(Stage), 32'd0);
    chk("t6_bus", 32'(MEM_r_w_z_z), 32'h2);
    chk("t6_count", Instr_Count, 32'd0);
    chk("t6_wait", 32'(Mem_Wait), 32'd0);
    chk("t6_strobe", 32'(Stage_Strobe), 32'd0);
    Run = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    tick();
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
